// File: rtl/butterfly_pkg.sv
// Shared types and constants for the ButterFly data-memory responder.
package butterfly_pkg;

  localparam int DMEM_WAIT_W         = 4;
  localparam int DMEM_BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

endpackage

// File: rtl/dmem_sram_1rw.sv
// Single-port word SRAM: synchronous read, per-byte write enables, no reset on contents.
module dmem_sram_1rw #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk_i,
  input  logic          en_i,
  input  logic [3:0]    we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_rdata;

  // Read returns the pre-write word on a write cycle; the responder never uses it then.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      for (int b = 0; b < 4; b++) begin
        if (we_i[b]) begin
          r_mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
      r_rdata <= r_mem[addr_i];
    end
  end

  assign rdata_o = r_rdata;

endmodule

// File: rtl/butterfly_dmem.sv
// Data-memory responder for the dmem_* valid/ready port: request latch, wait-state
// counter and range check in front of a byte-writable SRAM.
module butterfly_dmem
  import butterfly_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        dmem_valid_i,
  input  logic        dmem_we_i,
  input  logic [31:0] dmem_addr_i,
  input  logic [31:0] dmem_wdata_i,
  input  logic [3:0]  dmem_wstrb_i,
  output logic [31:0] dmem_rdata_o,
  output logic        dmem_ready_o,
  output logic        dmem_err_o
);

  localparam int                     AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0]            SPAN      = 32'(DEPTH_WORDS * DMEM_BYTES_PER_WORD);
  localparam logic [DMEM_WAIT_W-1:0] WAIT_LOAD = DMEM_WAIT_W'(WAIT_CYCLES);
  localparam logic [DMEM_WAIT_W-1:0] CNT_ONE   = DMEM_WAIT_W'(1);
  localparam bit                     ZERO_WAIT = (WAIT_CYCLES == 0);

  dmem_state_e            r_state;
  logic [DMEM_WAIT_W-1:0] r_cnt;
  logic                   r_we;
  logic [31:0]            r_addr;
  logic [31:0]            r_wdata;
  logic [3:0]             r_wstrb;
  logic                   r_ready;
  logic                   r_err;
  logic                   r_rd_sel;

  logic                   w_we;
  logic [31:0]            w_addr;
  logic [31:0]            w_wdata;
  logic [3:0]             w_wstrb;
  logic [31:0]            w_off;
  logic                   w_in_range;
  logic                   w_go_resp;
  logic                   w_sram_en;
  logic [3:0]             w_sram_we;
  logic [31:0]            w_sram_rdata;

  // With zero wait states the SRAM is accessed on the same edge that accepts the
  // request, so the live inputs stand in for the not-yet-latched request.
  always_comb begin
    w_we       = (r_state == IDLE) ? dmem_we_i    : r_we;
    w_addr     = (r_state == IDLE) ? dmem_addr_i  : r_addr;
    w_wdata    = (r_state == IDLE) ? dmem_wdata_i : r_wdata;
    w_wstrb    = (r_state == IDLE) ? dmem_wstrb_i : r_wstrb;
    w_off      = w_addr - BASE_ADDR;
    w_in_range = (w_off < SPAN);
    w_go_resp  = ((r_state == IDLE) && dmem_valid_i && ZERO_WAIT) ||
                 ((r_state == WAIT) && (r_cnt == CNT_ONE));
    w_sram_en  = w_go_resp && w_in_range && rst_n_i;
    w_sram_we  = w_we ? w_wstrb : 4'b0000;
  end

  dmem_sram_1rw #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_sram (
    .clk_i  (clk_i),
    .en_i   (w_sram_en),
    .we_i   (w_sram_we),
    .addr_i (w_off[AW+1:2]),
    .wdata_i(w_wdata),
    .rdata_o(w_sram_rdata)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
      r_ready  <= 1'b0;
      r_err    <= 1'b0;
      r_rd_sel <= 1'b0;
    end else begin
      r_ready  <= w_go_resp;
      r_err    <= w_go_resp && !w_in_range;
      r_rd_sel <= w_go_resp && w_in_range && !w_we;
      case (r_state)
        IDLE: begin
          if (dmem_valid_i) begin
            r_we    <= dmem_we_i;
            r_addr  <= dmem_addr_i;
            r_wdata <= dmem_wdata_i;
            r_wstrb <= dmem_wstrb_i;
            r_cnt   <= WAIT_LOAD;
            r_state <= ZERO_WAIT ? RESP : WAIT;
          end
        end
        WAIT: begin
          r_cnt <= r_cnt - CNT_ONE;
          if (r_cnt == CNT_ONE) begin
            r_state <= RESP;
          end
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign dmem_ready_o = r_ready;
  assign dmem_err_o   = r_err;
  assign dmem_rdata_o = r_rd_sel ? w_sram_rdata : 32'h0;

endmodule
